// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register.
//
// Carries a WIDTH-bit opaque payload plus a halt tag from one pipeline stage
// to the next. With SKID=1 a second (skid) entry is built so in_ready depends
// only on flops; with SKID=0 a single entry is kept and in_ready is
// combinational from out_ready. flush squashes all held entries on the next
// edge, and halt is a sticky flag raised once a halt-tagged entry is consumed.
//
// Optional build macro: PIPE_STATS_EN adds the stall_cnt / drop_cnt
// statistics outputs. Without it the port list carries no extra ports.

module pipe_stage_reg #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      SKID       = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    output logic             halt,
    output logic [1:0]       occupancy
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [15:0]      drop_cnt
`endif
);

    // Head (main) entry state.
    logic             main_v_r;
    logic [WIDTH-1:0] main_data_r;
    logic             main_halt_r;
    logic             halt_r;

    // Next-state values for the head entry.
    logic             main_v_nxt_s;
    logic [WIDTH-1:0] main_data_nxt_s;
    logic             main_halt_nxt_s;

    // View of the skid entry (constant empty when it is not built).
    logic             skid_v_s;
    logic [WIDTH-1:0] skid_data_s;
    logic             skid_halt_s;

    logic             in_ready_s;
    logic             accept_s;
    logic             pop_s;
    logic [1:0]       occupancy_s;

    assign accept_s    = in_valid && in_ready_s;
    assign pop_s       = main_v_r && out_ready;
    assign occupancy_s = {1'b0, main_v_r} + {1'b0, skid_v_s};

    generate
        if (SKID != 0) begin : g_skid
            logic             skid_v_r;
            logic [WIDTH-1:0] skid_data_r;
            logic             skid_halt_r;
            logic             skid_load_s;
            logic             skid_v_nxt_s;

            // An offer arriving while the head is held and not leaving parks in the skid slot.
            assign skid_load_s  = accept_s && main_v_r && !pop_s && !flush;
            assign skid_v_nxt_s = flush    ? 1'b0 :
                                  skid_v_r ? !pop_s :
                                             skid_load_s;

            // Skid entry register: valid cleared by flush, payload only by reset.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    skid_v_r    <= 1'b0;
                    skid_data_r <= RESET_DATA;
                    skid_halt_r <= 1'b0;
                end else begin
                    skid_v_r <= skid_v_nxt_s;
                    if (skid_load_s) begin
                        skid_data_r <= in_data;
                        skid_halt_r <= in_halt;
                    end else begin
                        skid_data_r <= skid_data_r;
                        skid_halt_r <= skid_halt_r;
                    end
                end
            end

            assign skid_v_s    = skid_v_r;
            assign skid_data_s = skid_data_r;
            assign skid_halt_s = skid_halt_r;
            // Registered backpressure: only the skid flop decides.
            assign in_ready_s  = !skid_v_r;
        end else begin : g_no_skid
            assign skid_v_s    = 1'b0;
            assign skid_data_s = RESET_DATA;
            assign skid_halt_s = 1'b0;
            // Single entry: room exists if empty or the head leaves this cycle.
            assign in_ready_s  = !main_v_r || out_ready;
        end
    endgenerate

    // Head-entry next state, keyed on the {skid_v, main_v} occupancy state.
    always_comb begin
        main_v_nxt_s    = main_v_r;
        main_data_nxt_s = main_data_r;
        main_halt_nxt_s = main_halt_r;
        if (flush) begin
            // Squash wins over any same-cycle accept; payload is left in place.
            main_v_nxt_s = 1'b0;
        end else begin
            case ({skid_v_s, main_v_r})
                2'b00: begin
                    if (accept_s) begin
                        main_v_nxt_s    = 1'b1;
                        main_data_nxt_s = in_data;
                        main_halt_nxt_s = in_halt;
                    end else begin
                        main_v_nxt_s = 1'b0;
                    end
                end
                2'b01: begin
                    if (accept_s && pop_s) begin
                        main_data_nxt_s = in_data;
                        main_halt_nxt_s = in_halt;
                    end else if (pop_s) begin
                        main_v_nxt_s = 1'b0;
                    end else begin
                        // Hold, or the new entry goes to the skid slot.
                        main_v_nxt_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (pop_s) begin
                        main_data_nxt_s = skid_data_s;
                        main_halt_nxt_s = skid_halt_s;
                    end else begin
                        main_v_nxt_s = 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable; recover to empty.
                    main_v_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Head entry and sticky halt registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_v_r    <= 1'b0;
            main_data_r <= RESET_DATA;
            main_halt_r <= 1'b0;
            halt_r      <= 1'b0;
        end else begin
            main_v_r    <= main_v_nxt_s;
            main_data_r <= main_data_nxt_s;
            main_halt_r <= main_halt_nxt_s;
            // A pop still consumes the head even when flush squashes the stage.
            halt_r      <= halt_r || (pop_s && main_halt_r);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = main_v_r;
    assign out_data  = main_data_r;
    assign out_halt  = main_halt_r;
    assign halt      = halt_r;
    assign occupancy = occupancy_s;

`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [15:0] drop_cnt_r;
    logic [16:0] drop_sum_s;

    assign drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, occupancy_s};

    // Saturating stall and flush-drop statistics; only reset clears them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= 32'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            if (main_v_r && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush) begin
                drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign drop_cnt  = drop_cnt_r;
`else
    // Statistics build disabled: no counters exist.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: a SKID=1 instance carries the main
// sequence, a SKID=0 instance covers the combinational in_ready variant and,
// when PIPE_STATS_EN is defined, the statistics counters.

module tb_pipe_stage_reg;

    logic        clk;
    logic        n_rst;

    // SKID=1 instance signals
    logic        in_valid, in_ready, in_halt, flush;
    logic [31:0] in_data, out_data;
    logic        out_valid, out_ready, out_halt, halt;
    logic [1:0]  occupancy;

    // SKID=0 instance signals
    logic        in_valid0, in_ready0, in_halt0, flush0;
    logic [31:0] in_data0, out_data0;
    logic        out_valid0, out_ready0, out_halt0, halt0;
    logic [1:0]  occupancy0;
`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt, stall_cnt0;
    logic [15:0] drop_cnt, drop_cnt0;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    pipe_stage_reg #(.WIDTH(32), .SKID(1)) u_dut (
        .CLK(clk), .nRST(n_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
        .halt(halt), .occupancy(occupancy)
`ifdef PIPE_STATS_EN
        , .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
`endif
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0)) u_dut0 (
        .CLK(clk), .nRST(n_rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_halt(in_halt0),
        .flush(flush0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_halt(out_halt0),
        .halt(halt0), .occupancy(occupancy0)
`ifdef PIPE_STATS_EN
        , .stall_cnt(stall_cnt0), .drop_cnt(drop_cnt0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        in_valid = 1'b0; in_data = 32'h0; in_halt = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_data0 = 32'h0; in_halt0 = 1'b0; flush0 = 1'b0; out_ready0 = 1'b0;

        // Values while reset is asserted
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready0", 32'(in_ready0), 32'd1);
        #5 n_rst = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // First transfer: one-cycle latency
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data", out_data, 32'hDEADBEEF);
        chk("lat_occ", 32'(occupancy), 32'd1);
        tick();
        chk("lat_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure fills main then skid
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        chk("bp_occ1", 32'(occupancy), 32'd1);
        chk("bp_in_ready1", 32'(in_ready), 32'd1);
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head_a", out_data, 32'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", out_data, 32'h22);
        chk("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
        chk("bp_occ_after_pop", 32'(occupancy), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Back-to-back stream with simultaneous accept and pop
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", out_data, 32'(i));
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // Flush in FULL with a same-cycle offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_data = 32'h55;
        tick();
        chk("fl_full_occ", 32'(occupancy), 32'd2);
        in_data = 32'h33; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_halt", 32'(halt), 32'd0);
        chk("fl_data_kept", out_data, 32'h44);
        out_ready = 1'b1;
        tick();
        chk("fl_no_ghost", 32'(out_valid), 32'd0);

        // Halt entry flushed before it is popped
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h66; in_halt = 1'b1;
        tick();
        in_valid = 1'b0; in_halt = 1'b0;
        chk("hf_out_halt", 32'(out_halt), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hf_halt_clear", 32'(halt), 32'd0);
        chk("hf_out_valid", 32'(out_valid), 32'd0);

        // Halt entry popped sets sticky halt
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h77; in_halt = 1'b1;
        tick();
        in_valid = 1'b0; in_halt = 1'b0;
        chk("hp_head_halt", 32'(out_halt), 32'd1);
        chk("hp_halt_pre", 32'(halt), 32'd0);
        tick();
        chk("hp_halt_set", 32'(halt), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hp_halt_survives_flush", 32'(halt), 32'd1);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h88;
        tick();
        in_valid = 1'b0;
        chk("mr_occ_pre", 32'(occupancy), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("mr_halt", 32'(halt), 32'd0);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_occ", 32'(occupancy), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        #2 n_rst = 1'b1;
        tick();

        // Flush with a same-cycle pop of a halt entry still sets halt
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h99; in_halt = 1'b1;
        tick();
        in_valid = 1'b0; in_halt = 1'b0;
        chk("fp_halt_pre", 32'(halt), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fp_halt_set", 32'(halt), 32'd1);
        chk("fp_out_valid", 32'(out_valid), 32'd0);

        // SKID=0: stream, stall, combinational in_ready, flush
        out_ready0 = 1'b1;
        in_valid0 = 1'b1; in_data0 = 32'hB1;
        tick();
        chk("s0_data1", out_data0, 32'hB1);
        in_data0 = 32'hB2;
        tick();
        chk("s0_data2", out_data0, 32'hB2);
        chk("s0_occ", 32'(occupancy0), 32'd1);
        in_valid0 = 1'b0;
        tick();
        chk("s0_drain", 32'(out_valid0), 32'd0);
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_data0 = 32'hA1;
        tick();
        in_valid0 = 1'b0;
        chk("s0_held", 32'(out_valid0), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("s0_in_ready_stall", 32'(in_ready0), 32'd0);
        chk("s0_head_kept", out_data0, 32'hA1);
`ifdef PIPE_STATS_EN
        chk("s0_stall_cnt", stall_cnt0, 32'd5);
`endif
        out_ready0 = 1'b1;
        #1;
        chk("s0_in_ready_comb", 32'(in_ready0), 32'd1);
        out_ready0 = 1'b0;
        #1;
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        chk("s0_flush_occ", 32'(occupancy0), 32'd0);
        chk("s0_flush_in_ready", 32'(in_ready0), 32'd1);
`ifdef PIPE_STATS_EN
        chk("s0_drop_cnt", 32'(drop_cnt0), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
